// File: rtl/pvr_param_cache_dm.sv
// rtl/pvr_param_cache_dm.sv - direct-mapped PVR parameter read cache; optional stats via PARAM_CACHE_STATS_EN
module pvr_param_cache_dm #(
    parameter int ADDR_W     = 22,
    parameter int LINE_WORDS = 32,
    parameter int LINES      = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] param_req_addr,
    input  logic              param_read,
    output logic [31:0]       param_dout,
    output logic              param_data_ready,
    input  logic              invalidate,
    output logic              busy,
    input  logic              ddram_waitrequest,
    output logic [ADDR_W-1:0] ddram_addr,
    output logic [7:0]        ddram_burstcnt,
    output logic              ddram_read_burst,
    input  logic [31:0]       ddram_readdata,
    input  logic              ddram_readdata_valid,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(LINES);
    localparam int IW = (IB > 0) ? IB : 1;
    localparam int TW = ADDR_W - OB - IB;
    localparam int RW = IW + OB;
    localparam logic [OB:0] LAST_BEAT = (OB+1)'(LINE_WORDS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LINES-1:0]  valid;
    logic              kill;
    logic [OB:0]       beat_cnt;
    logic [31:0]       mem [LINES*LINE_WORDS];
    logic [TW-1:0]     tag_mem [LINES];
    logic [31:0]       ram_q;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [OB-1:0] off;
    logic [RW-1:0] rd_addr;
    logic [RW-1:0] wr_addr;
    logic          hit;
    logic          beat_wr;
    logic          fill_last;
    logic          rd_en;

    generate
        if (IB > 0) begin : g_idx
            assign idx = addr_q[OB+IB-1:OB];
        end else begin : g_no_idx
            assign idx = '0;
        end
    endgenerate

    assign tag     = addr_q[ADDR_W-1:OB+IB];
    assign off     = addr_q[OB-1:0];
    assign rd_addr = {idx, off};
    assign wr_addr = {idx, beat_cnt[OB-1:0]};
    assign hit     = valid[idx] && (tag_mem[idx] == tag);

    // A beat is only ours once the burst has been accepted; stale beats in IDLE/LOOKUP are dropped.
    assign beat_wr   = reset_n && ddram_readdata_valid &&
                       ((state == ST_REQ && !ddram_waitrequest) || state == ST_FILL);
    assign fill_last = beat_wr && (beat_cnt == LAST_BEAT);
    assign rd_en     = (state == ST_LOOKUP) || fill_last;

    assign busy           = (state != ST_IDLE);
    assign ddram_burstcnt = 8'(LINE_WORDS);

    // Forward the last beat when the requested word is the one being written this cycle.
    always_ff @(posedge clock) begin
        if (beat_wr)
            mem[wr_addr] <= ddram_readdata;
        if (fill_last)
            tag_mem[idx] <= tag;
        if (rd_en)
            ram_q <= (beat_wr && (wr_addr == rd_addr)) ? ddram_readdata : mem[rd_addr];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            addr_q           <= '0;
            valid            <= '0;
            kill             <= 1'b0;
            beat_cnt         <= '0;
            param_dout       <= '0;
            param_data_ready <= 1'b0;
            ddram_addr       <= '0;
            ddram_read_burst <= 1'b0;
        end else begin
            param_data_ready <= 1'b0;
            if (beat_wr)
                beat_cnt <= beat_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (param_read) begin
                        addr_q <= param_req_addr;
                        kill   <= 1'b0;
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        state <= ST_DONE;
                    end else begin
                        ddram_addr       <= {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
                        ddram_read_burst <= 1'b1;
                        beat_cnt         <= '0;
                        state            <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!ddram_waitrequest) begin
                        ddram_read_burst <= 1'b0;
                        state            <= fill_last ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_last)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    param_dout       <= ram_q;
                    param_data_ready <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // An invalidate seen after the lookup poisons the in-flight fill so its line stays invalid.
            if (invalidate && (state == ST_LOOKUP || state == ST_REQ || state == ST_FILL))
                kill <= 1'b1;
            if (invalidate)
                valid <= '0;
            else if (fill_last && !kill)
                valid[idx] <= 1'b1;
        end
    end

`ifdef PARAM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n || invalidate) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_pvr_param_cache_dm.sv
// tb/tb_pvr_param_cache_dm.sv - scoreboard bench for pvr_param_cache_dm
module tb_pvr_param_cache_dm;
    localparam int ADDR_W = 22;
    localparam int LW     = 32;
    localparam int NL     = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] param_req_addr;
    logic              param_read;
    logic [31:0]       param_dout;
    logic              param_data_ready;
    logic              invalidate;
    logic              busy;
    logic              ddram_waitrequest;
    logic [ADDR_W-1:0] ddram_addr;
    logic [7:0]        ddram_burstcnt;
    logic              ddram_read_burst;
    logic [31:0]       ddram_readdata;
    logic              ddram_readdata_valid;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    pvr_param_cache_dm #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .LINES(NL)) dut (
        .clock(clock), .reset_n(reset_n),
        .param_req_addr(param_req_addr), .param_read(param_read),
        .param_dout(param_dout), .param_data_ready(param_data_ready),
        .invalidate(invalidate), .busy(busy),
        .ddram_waitrequest(ddram_waitrequest), .ddram_addr(ddram_addr),
        .ddram_burstcnt(ddram_burstcnt), .ddram_read_burst(ddram_read_burst),
        .ddram_readdata(ddram_readdata), .ddram_readdata_valid(ddram_readdata_valid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          ref_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

    bit   mvalid[NL];
    int   mtag[NL];
    int   mhit;
    int   mmiss;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock)
        if (reset_n && ddram_read_burst && !ddram_waitrequest) acc_cnt <= acc_cnt + 1;

    function automatic logic [31:0] ddr_word(input int a);
        return 32'hA000_0000 + 32'(a) - 32'h40;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic hard_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    always @(negedge clock) begin
        if (reset_n && param_data_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got dout %h expected no response", param_dout);
            end else begin
                mon_e = exp_q.pop_front();
                chk("dout", param_dout, mon_e.data);
                chk("latency", 32'(cyc - mon_e.ref_cyc), 32'(mon_e.lat));
            end
        end
    end

    task automatic model_inv();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
        mhit  = 0;
        mmiss = 0;
    endtask

    task automatic check_stats();
`ifdef PARAM_CACHE_STATS_EN
        chk("hit_count", hit_count, 32'(mhit));
        chk("miss_count", miss_count, 32'(mmiss));
`else
        chk("hit_count", hit_count, 32'd0);
        chk("miss_count", miss_count, 32'd0);
`endif
    endtask

    task automatic recover();
        reset_n = 1'b0;
        ddram_waitrequest = 1'b0;
        ddram_readdata_valid = 1'b0;
        invalidate = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        model_inv();
        exp_q.delete();
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        while (busy && t < 60) begin
            @(posedge clock); #1;
            t++;
        end
        ok = !busy;
        if (!ok) begin
            hard_fail("idle_timeout");
            recover();
        end
    endtask

    task automatic do_read(input int a, input int waits, input bit inv_issue,
                           input int inv_beat, input int rst_beat);
        int   idx, tag, line, acc0, t;
        bit   hit, killed, ok;
        exp_t e;
        idx  = (a >> 5) % NL;
        tag  = a >> 7;
        line = a & ~(LW - 1);
        acc0 = acc_cnt;
        if (inv_issue) model_inv();
        hit = mvalid[idx] && (mtag[idx] == tag);
        if (hit) mhit++; else mmiss++;

        param_req_addr    = a[ADDR_W-1:0];
        param_read        = 1'b1;
        invalidate        = inv_issue;
        ddram_waitrequest = (waits > 0);
        @(posedge clock); #1;
        param_read = 1'b0;
        invalidate = 1'b0;

        if (hit) begin
            e.data = ddr_word(a); e.ref_cyc = cyc; e.lat = 2;
            exp_q.push_back(e);
            wait_idle(ok);
            if (ok) begin
                chk("bursts_on_hit", 32'(acc_cnt - acc0), 32'd0);
                check_stats();
            end
            return;
        end

        t = 0;
        while (!ddram_read_burst && t < 8) begin
            @(posedge clock); #1;
            t++;
        end
        if (!ddram_read_burst) begin
            hard_fail("burst_timeout");
            recover();
            return;
        end
        chk("burst_addr", 32'(ddram_addr), 32'(line));
        chk("burstcnt", 32'(ddram_burstcnt), 32'(LW));
        for (int w = 0; w < waits; w++) begin
            @(posedge clock); #1;
            chk("burst_held", 32'(ddram_read_burst), 32'd1);
            chk("addr_held", 32'(ddram_addr), 32'(line));
        end

        killed = 1'b0;
        for (int i = 0; i < LW; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                ddram_readdata_valid = 1'b0;
                @(posedge clock); #1;
            end
            ddram_waitrequest    = 1'b0;
            ddram_readdata_valid = 1'b1;
            ddram_readdata       = ddr_word(line + i);
            if (i == inv_beat) begin
                invalidate = 1'b1;
                killed     = 1'b1;
            end
            if (i == rst_beat) reset_n = 1'b0;
            @(posedge clock); #1;
            invalidate = 1'b0;
            if (i == 0)
                chk("burst_dropped", 32'(ddram_read_burst), 32'd0);
            if (i == rst_beat) begin
                reset_n = 1'b1;
                model_inv();
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(param_data_ready), 32'd0);
                chk("rst_burst", 32'(ddram_read_burst), 32'd0);
                chk("rst_ddram_addr", 32'(ddram_addr), 32'd0);
                chk("rst_dout", param_dout, 32'd0);
                for (int j = i + 1; j < LW; j++) begin
                    ddram_readdata = 32'hDEAD_0000 + 32'(j);
                    @(posedge clock); #1;
                end
                ddram_readdata_valid = 1'b0;
                chk("stray_idle", 32'(busy), 32'd0);
                chk("stray_no_burst", 32'(acc_cnt - acc0), 32'd1);
                check_stats();
                return;
            end
        end
        ddram_readdata_valid = 1'b0;

        if (killed) begin
            model_inv();
        end else begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
        end
        e.data = ddr_word(a); e.ref_cyc = cyc; e.lat = 1;
        exp_q.push_back(e);
        wait_idle(ok);
        if (ok) begin
            chk("bursts_on_miss", 32'(acc_cnt - acc0), 32'd1);
            check_stats();
        end
    endtask

    initial begin
        reset_n              = 1'b0;
        param_req_addr       = '0;
        param_read           = 1'b0;
        invalidate           = 1'b0;
        ddram_waitrequest    = 1'b0;
        ddram_readdata       = '0;
        ddram_readdata_valid = 1'b0;
        model_inv();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(param_data_ready), 32'd0);
        chk("reset_burst", 32'(ddram_read_burst), 32'd0);
        chk("reset_ddram_addr", 32'(ddram_addr), 32'd0);
        chk("reset_dout", param_dout, 32'd0);
        check_stats();

        do_read('h45, 0, 1'b0, -1, -1);
        do_read('h4A, 0, 1'b0, -1, -1);
        do_read('h845, 0, 1'b0, -1, -1);
        do_read('h45, 0, 1'b0, -1, -1);
        do_read('h60, 5, 1'b0, -1, -1);
        do_read('h45, 0, 1'b0, -1, -1);

        invalidate = 1'b1;
        @(posedge clock); #1;
        invalidate = 1'b0;
        model_inv();
        check_stats();
        do_read('h45, 0, 1'b0, 10, -1);
        do_read('h45, 0, 1'b0, -1, -1);
        do_read('h45, 0, 1'b0, -1, -1);
        do_read('h8E5, 2, 1'b0, LW - 1, -1);
        do_read('h8E5, 0, 1'b0, -1, -1);
        do_read('h4A, 1, 1'b1, -1, -1);
        do_read('h45, 0, 1'b0, -1, 5);
        do_read('h45, 0, 1'b0, -1, -1);
        do_read('h4A, 0, 1'b0, -1, -1);

        for (int n = 0; n < 40; n++) begin
            int a;
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            do_read(a, $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(0, LW - 1) : -1, -1);
        end

        repeat (5) @(posedge clock);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pvr_param_cache_dm.md
Name: pvr_param_cache_dm

Overview:
Direct-mapped, multi-line read cache between the PVR TA/ISP parameter fetch logic and the DDRAM burst port. Each miss fills a whole line with one DDRAM burst. Hits return data without DDRAM traffic. This block supersedes the single-line, always-refetch parameter buffer, and adds tag/valid tracking, parametrised geometry and bulk invalidation.

Parameters:
ADDR_W, 22, word-address width of param_req_addr / ddram_addr
LINE_WORDS, 32, 32-bit words per line; power of 2, 2..128; also the burst length
LINES, 4, number of lines; power of 2, 1..64

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
param_req_addr  in  ADDR_W  requested word address; sampled when param_read accepted
param_read  in  1  request strobe; accepted only in IDLE
param_dout  out  32  read data; valid when param_data_ready=1, held until next ready pulse
param_data_ready  out  1  one-cycle completion pulse
invalidate  in  1  clear all valid bits
busy  out  1  high in any state other than IDLE
ddram_waitrequest  in  1  DDRAM stall
ddram_addr  out  ADDR_W  line-aligned burst word address
ddram_burstcnt  out  8  always LINE_WORDS
ddram_read_burst  out  1  burst request; held until accepted
ddram_readdata  in  32  burst beat data
ddram_readdata_valid  in  1  burst beat strobe
hit_count  out  32  see Optional Feature
miss_count  out  32  see Optional Feature

Behaviour:
- Address split: offset = addr[OB-1:0], OB=log2(LINE_WORDS); index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data RAM of LINES*LINE_WORDS x 32, one write port (fill), one synchronous read port; tag array and valid bit per line.
- Reset (synchronous): state=IDLE, all valid=0, param_data_ready=0, ddram_read_burst=0, busy=0, ddram_addr=0, param_dout=0, beat counter=0.
- State machine:
  - IDLE: on param_read, latch the address and go to LOOKUP.
  - LOOKUP: issue the RAM read at {index,offset}. If valid[index] and the tag matches, go to DONE. Otherwise set ddram_addr = {addr[ADDR_W-1:OB], OB'b0}, raise ddram_read_burst, clear the beat counter, and go to REQ.
  - REQ: hold ddram_read_burst and ddram_addr stable while ddram_waitrequest=1. In the cycle waitrequest=0, the burst is accepted: drop ddram_read_burst next cycle and go to FILL. Exactly one burst per miss.
  - FILL: on each readdata_valid, write the beat to RAM at {index, beat counter}, then beat counter +1. Beats may arrive while still in REQ (the acceptance cycle) and must be captured there too. After beat LINE_WORDS-1, write the tag and set valid (unless killed, see invalidate), re-issue the RAM read at {index,offset}, and go to DONE.
  - DONE: register RAM q into param_dout, pulse param_data_ready, return to IDLE.
- Latency: hit gives param_data_ready 3 cycles after the accept cycle (IDLE->LOOKUP->DONE->pulse edge). Miss gives ready 2 cycles after the last beat.
- param_read outside IDLE is ignored and not queued.
- readdata_valid in IDLE or LOOKUP (stale beats after a reset) is ignored: no RAM write.
- invalidate: clears all valid bits next cycle, in any state. If asserted during REQ/FILL, the in-flight fill completes and returns data to the requester, but its line is not marked valid. If invalidate and a fill completion coincide, invalidate wins. invalidate and param_read in the same IDLE cycle: clear first, and the request proceeds as a miss.
- Beat counter is log2(LINE_WORDS)+1 bits and never wraps past LINE_WORDS.

Optional Feature:
PARAM_CACHE_STATS_EN. When defined, hit_count and miss_count increment by 1 at the LOOKUP decision. They saturate at 0xFFFFFFFF and clear on reset or invalidate. When not defined, both ports are tied to 0 and no counter logic exists.

Test Plan:
- LINE_WORDS=32, LINES=4, cold read 0x000045 -> one burst: ddram_addr=0x000040, burstcnt=32. Feed beats 0xA0000000+i -> ready pulse with dout=0xA0000005.
- Then read 0x00004A -> no ddram_read_burst; ready exactly 3 cycles after accept, dout=0xA000000A.
- Read 0x000845 (same index 2, new tag) -> miss, burst at 0x000840. A following read of 0x000045 misses again (line evicted).
- Hold waitrequest=1 for 5 cycles on a miss -> ddram_read_burst and ddram_addr stable throughout; exactly one acceptance; fill completes correctly.
- Pulse invalidate at beat 10 of the fill for 0x000045 -> ready with the correct data. A re-read of 0x000045 misses (new burst). With PARAM_CACHE_STATS_EN, counters are 0 after the invalidate.
- Assert reset_n=0 for 1 cycle at beat 5 of a fill -> outputs at reset values. The remaining 26 stray beats cause no RAM writes. The next read of the same line misses and returns correct data.
